uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one byte at a time from NUM_REQ requesters into a
// single UART transmitter, with a watchdog on each transfer and a drain phase after it.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          tx_dv,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_active,
  input  logic                          tx_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      winner_q, winner_d;
  logic [CNT_W-1:0]      wdog_q, wdog_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic                  rr_found;
  logic [IDX_W-1:0]      rr_idx;
  logic [IDX_W-1:0]      rr_sel;
  logic                  wdog_expired;

  assign wdog_expired = (wdog_q == CNT_LAST);

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_LAST;
      winner_q     <= '0;
      wdog_q       <= '0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      wdog_q       <= wdog_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Scan downwards so the candidate closest after last_grant is written last and wins.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = last_grant_q;
    rr_idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      rr_idx = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (req[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    wdog_d       = wdog_q;
    tx_data_d    = tx_data_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          winner_d  = rr_sel;
          tx_data_d = DATA_WIDTH'(req_data >> (int'(rr_sel) * DATA_WIDTH));
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        last_grant_d = winner_q;
        wdog_d       = '0;
        state_d      = WAIT_DONE;
      end
      WAIT_DONE: begin
        // tx_done takes precedence over a simultaneous watchdog expiry.
        if (tx_done || wdog_expired) state_d = DRAIN;
        else                         wdog_d  = wdog_q + CNT_W'(1);
      end
      DRAIN: begin
        if (!tx_done && !tx_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant       = '0;
    tx_dv       = 1'b0;
    timeout_err = 1'b0;
    if (state_q == LAUNCH) begin
      tx_dv           = 1'b1;
      grant[winner_q] = 1'b1;
    end
    if (state_q == WAIT_DONE && !tx_done && wdog_expired) timeout_err = 1'b1;
  end

  assign busy    = (state_q != IDLE);
  assign tx_data = tx_data_q;

endmodule
